// File: rtl/fb_line_dither_pkg.sv
// fb_line_dither_pkg: shared sizes, types and dither helper for the line-dither stage
package fb_line_dither_pkg;
  localparam int X_WIDTH = 800;
  localparam int FB_DEPTH = 2;
  localparam int X_COORD_WIDTH = $clog2(X_WIDTH);
  localparam int COLOR_DEPTH_FB = 8;
  localparam int COLOR_DEPTH_VGA = 4;
  localparam int R_RANGE_FB_LO = 16;
  localparam int G_RANGE_FB_LO = 8;
  localparam int B_RANGE_FB_LO = 0;
  typedef enum logic [1:0] {EMPTY, FILL, FULL, READ} bank_state_t;
  // 4x4 Bayer matrix, element index {y, x}; row 0 is 0,8,2,10 from x = 0
  localparam logic [15:0][3:0] BAYER = 64'h5D7F_91B3_6E4C_A280;
  typedef struct packed {
    logic vld;
    logic row_done;
    logic frame_done;
    logic [X_COORD_WIDTH-1:0] x_coord;
    logic [3*COLOR_DEPTH_FB-1:0] val;
  } fb_t;
  typedef struct packed {
    logic [COLOR_DEPTH_VGA-1:0] r;
    logic [COLOR_DEPTH_VGA-1:0] g;
    logic [COLOR_DEPTH_VGA-1:0] b;
    logic hsync;
    logic vsync;
    logic display;
  } vga_t;
  // Round an 8-bit channel to 4 bits against the Bayer threshold, saturating at 15
  function automatic logic [COLOR_DEPTH_VGA-1:0] dither(input logic [COLOR_DEPTH_FB-1:0] c, input logic [1:0] y, input logic [1:0] x);
    logic [3:0] t;
    t = BAYER[{y, x}];
    return &c[7:4] ? c[7:4] : c[7:4] + 4'(c[3:0] > t);
  endfunction
endpackage

// File: rtl/fb_row_ram.sv
// fb_row_ram: simple dual-port row RAM, synchronous read, addressed as {bank, x}
module fb_row_ram #(
  parameter int AW = 11,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  // Write and registered read ports, no reset so the array maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fb_line_dither.sv
// fb_line_dither: ping-pong row buffer replayed under VGA timing with 4x4 ordered dither
module fb_line_dither #(
  parameter int X_WIDTH = fb_line_dither_pkg::X_WIDTH,
  parameter int BANKS = fb_line_dither_pkg::FB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  fb_line_dither_pkg::fb_t    fb,
  output logic                       wr_ready,
  output logic                       overrun,
  input  logic                       line_start,
  input  logic                       frame_start,
  input  logic                       disp_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  output fb_line_dither_pkg::vga_t   vga,
  output logic                       underrun
);
  import fb_line_dither_pkg::*;
  localparam int XW = X_COORD_WIDTH;
  localparam int AW = $clog2(BANKS) + XW;
  bank_state_t [1:0] st, st_n;
  logic wb, rb, wb_n, rb_n, rb_a, rd_bank, wr_open, close, rd_en, last;
  logic [XW-1:0] rptr, rptr_n, fetch_x;
  logic [1:0] y, line_y, fetch_y, x1, y1;
  logic pix1;
  logic [2:0] tim1;
  logic [23:0] rdata;
  // Bank bookkeeping: writes only touch EMPTY/FILL banks and reads only FULL/READ, so both sides update independently
  always_comb begin
    st_n = st;
    wr_open = st[wb] == EMPTY || st[wb] == FILL;
    close = wr_open && (fb.row_done || fb.frame_done);
    if (wr_open && fb.vld) st_n[wb] = FILL;
    if (close) st_n[wb] = FULL;
    wb_n = close ? ~wb : wb;
    rb_a = (line_start && st[rb] == READ) ? ~rb : rb;
    if (line_start && st[rb] == READ) st_n[rb] = EMPTY;
    if (line_start && st[rb_a] == FULL) st_n[rb_a] = READ;
    rd_bank = line_start ? rb_a : rb;
    rd_en = disp_in && (line_start ? st[rb_a] == FULL : st[rb] == READ);
    fetch_x = line_start ? '0 : rptr;
    fetch_y = line_start ? y : line_y;
    last = rd_en && fetch_x == XW'(X_WIDTH - 1);
    if (last) st_n[rd_bank] = EMPTY;
    rb_n = last ? ~rd_bank : rd_bank;
    rptr_n = last ? '0 : rd_en ? fetch_x + 1'b1 : fetch_x;
  end
  // Bank states, pointers, line counter and status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= '{EMPTY, EMPTY};
      wb <= 1'b0;
      rb <= 1'b0;
      rptr <= '0;
      y <= '0;
      line_y <= '0;
      wr_ready <= 1'b1;
      overrun <= 1'b0;
      underrun <= 1'b0;
    end else begin
      st <= st_n;
      wb <= wb_n;
      rb <= rb_n;
      rptr <= rptr_n;
      y <= frame_start ? 2'd0 : line_start ? y + 2'd1 : y;
      line_y <= line_start ? y : line_y;
      wr_ready <= st_n[wb_n] == EMPTY || st_n[wb_n] == FILL;
      overrun <= fb.vld && !wr_open;
      underrun <= line_start && st[rb_a] != FULL;
    end
  end
  fb_row_ram #(.AW(AW), .DW(24)) u_ram (
    .clk   (clk),
    .we    (wr_open && fb.vld),
    .waddr ({wb, fb.x_coord}),
    .wdata (fb.val),
    .re    (rd_en),
    .raddr ({rd_bank, fetch_x}),
    .rdata (rdata)
  );
  // Two-stage output: stage 1 tracks the RAM read, stage 2 dithers and blanks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      tim1 <= '0;
      vga <= '0;
    end else begin
      pix1 <= rd_en;
      x1 <= fetch_x[1:0];
      y1 <= fetch_y;
      tim1 <= {hsync_in, vsync_in, disp_in};
      vga.hsync <= tim1[2];
      vga.vsync <= tim1[1];
      vga.display <= tim1[0];
      vga.r <= (pix1 && tim1[0]) ? dither(rdata[R_RANGE_FB_LO +: COLOR_DEPTH_FB], y1, x1) : '0;
      vga.g <= (pix1 && tim1[0]) ? dither(rdata[G_RANGE_FB_LO +: COLOR_DEPTH_FB], y1, x1) : '0;
      vga.b <= (pix1 && tim1[0]) ? dither(rdata[B_RANGE_FB_LO +: COLOR_DEPTH_FB], y1, x1) : '0;
    end
  end
endmodule

// File: tb/tb_fb_line_dither.sv
// tb_fb_line_dither: directed checks of row buffering, dither, underrun, overrun and reset
module tb_fb_line_dither;
  import fb_line_dither_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fb_t fb;
  vga_t vga;
  logic wr_ready, overrun, underrun, line_start, frame_start, disp_in, hsync_in, vsync_in;
  int n_chk = 0;
  int n_ok = 0;
  int ly = 0;
  int bay [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
  always #5 clk = ~clk;
  fb_line_dither dut (
    .clk         (clk),
    .rst         (rst),
    .fb          (fb),
    .wr_ready    (wr_ready),
    .overrun     (overrun),
    .line_start  (line_start),
    .frame_start (frame_start),
    .disp_in     (disp_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .vga         (vga),
    .underrun    (underrun)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [3:0] model(input int c, input int x, input int yy);
    int v;
    v = c / 16 + ((c % 16) > bay[(yy % 4) * 4 + x % 4] ? 1 : 0);
    return 4'(v > 15 ? 15 : v);
  endfunction
  function automatic logic [23:0] pix(input int mode, input logic [23:0] base, input int x);
    logic [7:0] xb;
    xb = 8'(x);
    return mode == 2 ? {xb, xb ^ 8'h5A, 8'hC3 + xb} : base;
  endfunction
  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    ly = 0;
  endtask
  task automatic write_row(input int mode, input logic [23:0] base);
    for (int x = 0; x < X_WIDTH; x++) begin
      @(negedge clk);
      fb.vld = 1'b1;
      fb.x_coord = X_COORD_WIDTH'(x);
      fb.val = pix(mode, base, x);
      fb.row_done = (x == X_WIDTH - 1);
    end
    @(negedge clk);
    fb = '0;
  endtask
  task automatic play_line(input int mode, input logic [23:0] base, input string tag);
    logic [23:0] p;
    logic [12:0] e;
    for (int i = 0; i < X_WIDTH + 2; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({tag, " display delay"}, 32'(vga.display), 32'd0);
        check({tag, " underrun"}, 32'(underrun), 32'(mode == 0));
      end
      if (i == 2) begin
        check({tag, " underrun one pulse"}, 32'(underrun), 32'd0);
        check({tag, " hsync delay"}, 32'(vga.hsync), 32'd1);
      end
      if (i >= 2) begin
        p = pix(mode, base, i - 2);
        e = mode == 0 ? 13'd1 : {model(p[23:16], i - 2, ly), model(p[15:8], i - 2, ly), model(p[7:0], i - 2, ly), 1'b1};
        check($sformatf("%s px%0d", tag, i - 2), 32'({vga.r, vga.g, vga.b, vga.display}), 32'(e));
      end
      line_start = (i == 0);
      hsync_in = (i == 0);
      disp_in = (i < X_WIDTH);
    end
    ly = (ly + 1) % 4;
  endtask
  initial begin
    fb = '0;
    line_start = 0;
    frame_start = 0;
    disp_in = 0;
    hsync_in = 0;
    vsync_in = 0;
    repeat (3) @(negedge clk);
    check("reset wr_ready", 32'(wr_ready), 32'd1);
    check("reset vga", 32'(vga), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset underrun", 32'(underrun), 32'd0);
    rst = 1'b0;
    write_row(1, 24'h808080);
    play_line(1, 24'h808080, "single");
    frame();
    write_row(1, 24'h474747);
    play_line(1, 24'h474747, "dither y0");
    write_row(1, 24'h474747);
    play_line(1, 24'h474747, "dither y1");
    write_row(1, 24'hFFFFFF);
    play_line(1, 24'hFFFFFF, "saturate");
    write_row(2, 24'h0);
    play_line(2, 24'h0, "pattern");
    play_line(0, 24'h0, "underrun");
    write_row(1, 24'h123456);
    play_line(1, 24'h123456, "after underrun");
    write_row(2, 24'h0);
    write_row(1, 24'hABCDEF);
    check("both full wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    fb.vld = 1'b1;
    fb.x_coord = '0;
    fb.val = 24'h0;
    @(negedge clk);
    fb = '0;
    check("overrun pulse", 32'(overrun), 32'd1);
    @(negedge clk);
    check("overrun one pulse", 32'(overrun), 32'd0);
    check("overrun wr_ready", 32'(wr_ready), 32'd0);
    play_line(2, 24'h0, "kept bank0");
    check("freed wr_ready", 32'(wr_ready), 32'd1);
    play_line(1, 24'hABCDEF, "kept bank1");
    write_row(1, 24'h808080);
    for (int i = 0; i < 402; i++) begin
      @(negedge clk);
      line_start = (i == 0);
      disp_in = 1'b1;
    end
    @(negedge clk);
    check("mid-read pixel", 32'({vga.r, vga.g, vga.b, vga.display}), 32'({4'd8, 4'd8, 4'd8, 1'b1}));
    rst = 1'b1;
    disp_in = 1'b0;
    #1;
    check("rst vga", 32'(vga), 32'd0);
    check("rst wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    ly = 0;
    play_line(0, 24'h0, "post-reset");
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
